// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch stage between the PC register and decode.
// Issues in-order imem requests from pc_in, tracks their PCs in a tag FIFO,
// buffers returned words and presents {pc, instr} to decode on valid/ready.
// Drives the PC register (sequential +4 on accept, or redirect target).
// Optional feature macro: FETCH_MISALIGN_TRAP_EN (misaligned redirect traps
// into FAULT and presents a single if_fault entry).
module fetch_unit #(
  parameter logic [31:0] RESET_ADDR = 32'h0100_0000,
  parameter int          BUF_DEPTH  = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc_in,
  output logic        pc_en,
  output logic [31:0] pc_next,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        halt,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_pc,
  output logic [31:0] if_instr,
  output logic        if_fault
);

  localparam int AW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int CW = $clog2(BUF_DEPTH + 1);
  // Stale responses can pile up across back-to-back redirects; leave headroom.
  localparam int DW = CW + 4;
  localparam logic [CW:0] DEPTH_L = BUF_DEPTH[CW:0];

`ifdef FETCH_MISALIGN_TRAP_EN
  typedef enum logic [1:0] {RUN, HALTED, FAULT} state_t;
`else
  typedef enum logic [1:0] {RUN, HALTED} state_t;
`endif

  state_t        state, state_n;
  logic [31:0]   buf_pc    [BUF_DEPTH];
  logic [31:0]   buf_instr [BUF_DEPTH];
  logic [AW-1:0] buf_wp, buf_rp;
  logic [CW-1:0] buf_cnt;
  logic [31:0]   tag_mem   [BUF_DEPTH];
  logic [AW-1:0] tag_wp, tag_rp;
  logic [CW-1:0] outstanding;
  logic [DW-1:0] discard;
  logic [CW:0]   credit_used;
  logic          accept, rsp_keep, buf_push, buf_pop, fault_push;
  logic [31:0]   push_pc, push_instr, redir_target;
`ifdef FETCH_MISALIGN_TRAP_EN
  logic          redir_misaligned;
  logic          fault_pend;
  logic [31:0]   fault_pc;
  logic          buf_flt [BUF_DEPTH];
`endif

`ifdef FETCH_MISALIGN_TRAP_EN
  assign redir_target     = redirect_pc;
  assign redir_misaligned = (redirect_pc[1:0] != 2'b00);
`else
  assign redir_target     = redirect_pc & ~32'h3;
`endif

  // Credits: in-flight plus buffered entries never exceed the buffer size,
  // so a response always finds room.
  assign credit_used    = {1'b0, outstanding} + {1'b0, buf_cnt};
  assign imem_req_valid = !rst && (state == RUN) && !redirect_valid && (credit_used < DEPTH_L);
  assign imem_req_addr  = pc_in;
  assign accept         = imem_req_valid & imem_req_ready;

  // Enable is gated by rst because the PC register's enable beats its reset.
  assign pc_en   = !rst & (redirect_valid | accept);
  assign pc_next = redirect_valid ? redir_target : pc_in + 32'd4;

  // A response in the redirect cycle is stale by definition and is dropped.
  assign rsp_keep = imem_rsp_valid && (discard == '0) && !redirect_valid;
  assign if_valid = !rst && (buf_cnt != '0);
  assign buf_pop  = if_valid & if_ready;
  assign if_pc    = buf_pc[buf_rp];
  assign if_instr = buf_instr[buf_rp];

`ifdef FETCH_MISALIGN_TRAP_EN
  // Fault marker enters the buffer only once all stale words have drained.
  assign fault_push = (state == FAULT) && fault_pend && (discard == '0) && !redirect_valid;
  assign if_fault   = if_valid & buf_flt[buf_rp];
  assign push_pc    = fault_push ? fault_pc : tag_mem[tag_rp];
  assign push_instr = fault_push ? 32'h0 : imem_rsp_data;
`else
  assign fault_push = 1'b0;
  assign if_fault   = 1'b0;
  assign push_pc    = tag_mem[tag_rp];
  assign push_instr = imem_rsp_data;
`endif
  assign buf_push = rsp_keep | fault_push;

  // Next-state: redirect always wins; otherwise halt toggles RUN/HALTED.
  always_comb begin
    state_n = state;
    if (redirect_valid) begin
      state_n = halt ? HALTED : RUN;
`ifdef FETCH_MISALIGN_TRAP_EN
      if (redir_misaligned) state_n = FAULT;
`endif
    end else begin
      case (state)
        RUN:     if (halt)  state_n = HALTED;
        HALTED:  if (!halt) state_n = RUN;
        default: state_n = state;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= RUN;
    else     state <= state_n;
  end

  // Counters and pointers; redirect flushes everything and converts the
  // in-flight requests into responses to throw away.
  always_ff @(posedge clk) begin
    if (rst) begin
      outstanding <= '0;
      discard     <= '0;
      buf_cnt     <= '0;
      buf_wp      <= '0;
      buf_rp      <= '0;
      tag_wp      <= '0;
      tag_rp      <= '0;
    end else if (redirect_valid) begin
      outstanding <= '0;
      discard     <= discard + DW'(outstanding) - DW'(imem_rsp_valid);
      buf_cnt     <= '0;
      buf_wp      <= '0;
      buf_rp      <= '0;
      tag_wp      <= '0;
      tag_rp      <= '0;
    end else begin
      outstanding <= outstanding + CW'(accept) - CW'(rsp_keep);
      if (imem_rsp_valid && (discard != '0)) discard <= discard - DW'(1);
      buf_cnt <= buf_cnt + CW'(buf_push) - CW'(buf_pop);
      if (buf_push) buf_wp <= buf_wp + AW'(1);
      if (buf_pop)  buf_rp <= buf_rp + AW'(1);
      if (accept)   tag_wp <= tag_wp + AW'(1);
      if (rsp_keep) tag_rp <= tag_rp + AW'(1);
    end
  end

  // Tag FIFO storage: PC of each accepted request, in issue order.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < BUF_DEPTH; i++) tag_mem[i] <= RESET_ADDR;
    end else if (accept) begin
      tag_mem[tag_wp] <= pc_in;
    end
  end

  // Instruction buffer storage.
  always_ff @(posedge clk) begin
    if (!rst && buf_push) begin
      buf_pc[buf_wp]    <= push_pc;
      buf_instr[buf_wp] <= push_instr;
    end
  end

`ifdef FETCH_MISALIGN_TRAP_EN
  // Fault bookkeeping: remember the bad target until its marker is buffered.
  always_ff @(posedge clk) begin
    if (rst) begin
      fault_pend <= 1'b0;
      fault_pc   <= RESET_ADDR;
    end else if (redirect_valid) begin
      fault_pend <= redir_misaligned;
      fault_pc   <= redirect_pc;
    end else if (fault_push) begin
      fault_pend <= 1'b0;
    end
  end

  // Per-entry fault flag alongside the buffer.
  always_ff @(posedge clk) begin
    if (!rst && buf_push) buf_flt[buf_wp] <= fault_push;
  end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: scoreboard bench for fetch_unit. The bench owns a PC
// register, a variable-latency in-order memory, and a queue of expected
// {pc, instr, fault} entries pushed on accept and popped on decode handshake.
`timescale 1ns/1ps
module tb_fetch_unit;
  localparam logic [31:0] RESET_ADDR = 32'h0100_0000;
  localparam int          BUF_DEPTH  = 2;
  localparam int S_RUN = 0, S_HALT = 1, S_FAULT = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [31:0] pc_in, pc_q, pc_next, imem_req_addr, imem_rsp_data, redirect_pc, if_pc, if_instr;
  logic pc_en, imem_req_valid, imem_req_ready = 1'b0, imem_rsp_valid = 1'b0;
  logic redirect_valid = 1'b0, halt = 1'b0, if_valid, if_ready = 1'b0, if_fault;

  always #5 clk = ~clk;

  fetch_unit #(.RESET_ADDR(RESET_ADDR), .BUF_DEPTH(BUF_DEPTH)) dut (
    .clk(clk), .rst(rst), .pc_in(pc_in), .pc_en(pc_en), .pc_next(pc_next),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr), .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data(imem_rsp_data), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .halt(halt), .if_valid(if_valid),
    .if_ready(if_ready), .if_pc(if_pc), .if_instr(if_instr), .if_fault(if_fault)
  );

  // Environment PC register.
  always @(posedge clk) begin
    if (rst)        pc_q <= RESET_ADDR;
    else if (pc_en) pc_q <= pc_next;
  end
  assign pc_in = pc_q;

  typedef struct { logic [31:0] pc; logic [31:0] instr; logic flt; } ent_t;
  typedef struct { logic [31:0] addr; logic stale; int due; } mreq_t;
  ent_t  exp_q[$];
  mreq_t mq[$];

  int checks = 0, errors = 0;
  int cyc = 0, buf_m = 0, st_m = S_RUN, lat = 1, rdy_pct = 100, rrdy_pct = 100;
  int first_acc = -1, first_val = -1, acc_cnt = 0, fault_pops = 0;
  bit rst_cmd = 1'b1, halt_cmd = 1'b0, fault_pend_m = 1'b0, cur_stale = 1'b0;
  bit did_redir, last_req_valid, last_if_valid, mark_arm = 1'b0;
  logic [31:0] exp_pc = RESET_ADDR, mark_pc = '0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hDEAD_BEEF;
  endfunction

  function automatic logic [31:0] redir_tgt(input logic [31:0] r);
`ifdef FETCH_MISALIGN_TRAP_EN
    return r;
`else
    return r & ~32'h3;
`endif
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // One clock: drive at negedge, model/compare #1 later (before posedge).
  task automatic cycle(input bit redir, input logic [31:0] rpc, input bit need_rsp);
    mreq_t m;
    ent_t  e;
    bit    acc, exp_rv, rsp_in, rv;
    int    stale_n, due;
    @(negedge clk);
    rst            = rst_cmd;
    halt           = halt_cmd;
    if_ready       = ($urandom_range(99) < rdy_pct);
    imem_req_ready = ($urandom_range(99) < rrdy_pct);
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    cur_stale      = 1'b0;
    if (!rst_cmd && mq.size() != 0 && mq[0].due <= cyc) begin
      m = mq.pop_front();
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = mem_word(m.addr);
      cur_stale      = m.stale;
    end
    rv = redir && (!need_rsp || (imem_rsp_valid && !cur_stale));
    redirect_valid = rv;
    redirect_pc    = rpc;
    did_redir      = rv;
    #1;
    last_req_valid = imem_req_valid;
    last_if_valid  = if_valid;
    if (rst) begin
      chk("rst_pc_en", pc_en, 0);
      chk("rst_req_valid", imem_req_valid, 0);
      chk("rst_if_valid", if_valid, 0);
      chk("rst_if_fault", if_fault, 0);
      exp_q.delete(); mq.delete();
      buf_m = 0; st_m = S_RUN; exp_pc = RESET_ADDR; fault_pend_m = 1'b0;
      first_acc = -1; first_val = -1;
    end else begin
      acc    = imem_req_valid && imem_req_ready;
      exp_rv = (st_m == S_RUN) && !rv && (exp_q.size() < BUF_DEPTH);
      chk("req_valid", imem_req_valid, exp_rv);
      chk("if_valid", if_valid, buf_m > 0);
      if (buf_m > 0) chk("if_fault", if_fault, exp_q[0].flt);
      if (if_valid && first_val < 0) first_val = cyc;
      stale_n = 0;
      foreach (mq[i]) if (mq[i].stale) stale_n++;
      if (imem_rsp_valid && cur_stale) stale_n++;
      rsp_in = imem_rsp_valid && !cur_stale && !rv;
      if (rsp_in) chk("rsp_buf_room", buf_m < BUF_DEPTH, 1);
      if (rv) begin
        chk("redir_pc_en", pc_en, 1);
        chk("redir_pc_next", pc_next, redir_tgt(rpc));
      end else if (acc) begin
        chk("req_addr", imem_req_addr, exp_pc);
        chk("seq_pc_en", pc_en, 1);
        chk("seq_pc_next", pc_next, exp_pc + 32'd4);
        if (first_acc < 0) first_acc = cyc;
      end else begin
        chk("idle_pc_en", pc_en, 0);
      end
      if (if_valid && if_ready && buf_m > 0) begin
        e = exp_q.pop_front();
        buf_m--;
        chk("if_pc", if_pc, e.pc);
        chk("if_instr", if_instr, e.instr);
        if (e.flt) fault_pops++;
        if (mark_arm) begin mark_pc = e.pc; mark_arm = 1'b0; end
      end
      if (rsp_in) buf_m++;
      if (rv) begin
        exp_q.delete();
        buf_m = 0;
        foreach (mq[i]) mq[i].stale = 1'b1;
        exp_pc = redir_tgt(rpc);
        st_m = halt ? S_HALT : S_RUN;
        fault_pend_m = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
        if (rpc[1:0] != 2'b00) begin
          st_m = S_FAULT; fault_pend_m = 1'b1;
          e.pc = rpc; e.instr = 32'h0; e.flt = 1'b1;
          exp_q.push_back(e);
        end
`endif
      end else begin
        if (acc) begin
          e.pc = exp_pc; e.instr = mem_word(exp_pc); e.flt = 1'b0;
          exp_q.push_back(e);
          due = cyc + lat;
          if (mq.size() != 0 && mq[$].due >= due) due = mq[$].due + 1;
          m.addr = exp_pc; m.stale = 1'b0; m.due = due;
          mq.push_back(m);
          exp_pc = exp_pc + 32'd4;
          acc_cnt++;
        end
        if (st_m == S_FAULT) begin
          if (fault_pend_m && stale_n == 0) begin buf_m++; fault_pend_m = 1'b0; end
        end else begin
          st_m = halt ? S_HALT : S_RUN;
        end
      end
    end
    cyc++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 32'h0, 1'b0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int a0, live;
    bit found;
    // Reset, then streaming with 1-cycle memory and decode always ready.
    rst_cmd = 1'b1; run(3);
    rst_cmd = 1'b0; run(20);
    chk("first_if_latency", first_val - first_acc, 2);

    // Decode stalls: buffer fills to BUF_DEPTH and issue stops.
    rdy_pct = 0; run(5);
    chk("bp_req_blocked", last_req_valid, 0);
    chk("bp_if_valid", last_if_valid, 1);
    rdy_pct = 100; run(6);

    // Redirect with two requests in flight (3-cycle memory).
    lat = 3; found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      live = 0;
      foreach (mq[j]) if (!mq[j].stale) live++;
      if (live >= 2) found = 1'b1;
      else run(1);
    end
    chk("redir_two_outstanding", found, 1);
    cycle(1'b1, 32'h0100_0100, 1'b0);
    mark_arm = 1'b1; mark_pc = '0; run(12);
    chk("redir_first_pc", mark_pc, 32'h0100_0100);

    // Redirect coincident with a live response and imem ready.
    lat = 2; run(4); found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      cycle(1'b1, 32'h0100_0300, 1'b1);
      found = did_redir;
    end
    chk("coinc_redirect_seen", found, 1);
    chk("coinc_req_valid", last_req_valid, 0);
    mark_arm = 1'b1; mark_pc = '0; run(10);
    chk("coinc_first_pc", mark_pc, 32'h0100_0300);

    // Halt mid-stream: in-flight words drain, then resume in order.
    run(3);
    halt_cmd = 1'b1; run(1);
    a0 = acc_cnt; run(3);
    chk("halt_no_issue", acc_cnt - a0, 0);
    halt_cmd = 1'b0; run(10);

    // Sequential increment wraps at the top of the address space.
    lat = 1; cycle(1'b1, 32'hFFFF_FFF8, 1'b0); run(8);

    // Mixed random traffic with redirects, halts and varying latency.
    rdy_pct = 70; rrdy_pct = 75;
    for (int i = 0; i < 400; i++) begin
      if (i % 50 == 0) lat = $urandom_range(3, 1);
      if ($urandom_range(99) < 10) halt_cmd = !halt_cmd;
      if ($urandom_range(99) < 4)
        cycle(1'b1, RESET_ADDR + ({$urandom_range(255)} << 2), 1'b0);
      else
        run(1);
    end
    halt_cmd = 1'b0; rdy_pct = 100; rrdy_pct = 100; run(10);

`ifdef FETCH_MISALIGN_TRAP_EN
    // Misaligned redirect: one fault entry, no fetch until re-redirected.
    lat = 2; run(3);
    fault_pops = 0;
    cycle(1'b1, 32'h0100_0102, 1'b0);
    a0 = acc_cnt; run(10);
    chk("fault_entry_count", fault_pops, 1);
    chk("fault_no_issue", acc_cnt - a0, 0);
    cycle(1'b1, 32'h0100_0200, 1'b0);
    mark_arm = 1'b1; mark_pc = '0; run(8);
    chk("fault_resume_pc", mark_pc, 32'h0100_0200);
`else
    // Without the trap, low target bits are ignored for fetch.
    cycle(1'b1, 32'h0100_0102, 1'b0);
    mark_arm = 1'b1; mark_pc = '0; run(8);
    chk("misalign_masked_pc", mark_pc, 32'h0100_0100);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage directly downstream of the program counter register.
- Takes the current PC, issues in-order requests to instruction memory, and buffers the returned words with their PCs. Presents {pc, instr} to decode over a valid/ready handshake.
- Drives the PC register's enable/next-value inputs: sequential +4 on each accepted request, or the redirect target.

Parameters:
- RESET_ADDR, 32'h01000000: fetch address after reset; must equal the PC register's reset value.
- BUF_DEPTH, 2: instruction buffer entries; also the outstanding-request limit (power of 2, ≥2).

Ports:
- clk  in  1  clock
- rst  in  1  reset
- pc_in  in  32  current PC (PC register output)
- pc_en  out  1  PC register load enable
- pc_next  out  32  value loaded into PC when pc_en=1
- imem_req_valid  out  1  fetch request valid
- imem_req_ready  in  1  memory accepts request
- imem_req_addr  out  32  fetch address
- imem_rsp_valid  in  1  response word valid (in order, one per accepted request, no backpressure)
- imem_rsp_data  in  32  instruction word
- redirect_valid  in  1  branch/jump/trap redirect
- redirect_pc  in  32  redirect target
- halt  in  1  stop issuing new requests
- if_valid  out  1  instruction available to decode
- if_ready  in  1  decode accepts
- if_pc  out  32  PC of presented instruction
- if_instr  out  32  presented instruction
- if_fault  out  1  misaligned-fetch marker (see Optional Feature)

Behaviour:
- Reset: clock clk; reset rst, synchronous, active-high. While rst=1 or in the cycle it is sampled:
  - pc_en=0, imem_req_valid=0, if_valid=0, if_fault=0.
  - Buffer, tag FIFO, outstanding and discard counters cleared; FSM to RUN.
  - pc_en must stay 0 during rst, because the PC register's enable overrides its reset.
- FSM states: RUN, HALTED, FAULT (FAULT exists only with the macro).
  - RUN→HALTED when halt=1.
  - HALTED→RUN when halt=0.
  - redirect_valid in any state goes to RUN (halt permitting).
- Issue:
  - Condition: imem_req_valid = (state==RUN) & !redirect_valid & (outstanding + buf_count < BUF_DEPTH).
  - imem_req_addr = pc_in.
  - On accept (valid & ready): pc_en=1, pc_next=pc_in+4 (mod 2^32, wraps 0xFFFFFFFC→0); pc_in pushed to tag FIFO; outstanding+1.
- Redirect: has priority over issue in the same cycle.
  - pc_en=1, pc_next=redirect_pc; no request issued.
  - Buffer and tag FIFO flushed; if_valid=0 next cycle.
  - discard = outstanding minus (response arriving this cycle), plus existing discard. A response arriving in the redirect cycle is dropped.
- Response:
  - If discard>0: drop the word, discard−1.
  - Otherwise: write {tag FIFO head, rsp_data} into the buffer and pop the tag FIFO.
  - outstanding−1 on every non-discarded response.
  - Response-to-if_valid latency is 1 cycle. Accept→if_valid is minimum 2 cycles for single-cycle memory.
- Output:
  - if_valid = buffer not empty; head drives if_pc/if_instr.
  - Pop on if_valid & if_ready.
  - Push and pop in the same cycle leave the count unchanged.
  - if_pc/if_instr are held stable while if_valid & !if_ready.
- Credit rule guarantees a response never arrives with the buffer full. The bench asserts this; RTL need not check it.
- halt does not cancel outstanding requests; their responses still fill the buffer.

Optional Feature:
- Macro FETCH_MISALIGN_TRAP_EN.
- Defined: a redirect with redirect_pc[1:0]≠0 enters FAULT.
  - No issue in FAULT.
  - After in-flight/discarded responses drain, one entry is presented with if_fault=1, if_pc=redirect_pc, if_instr=0.
  - Stays in FAULT until the next redirect.
- Undefined: redirect_pc[1:0] forced to 0 for fetch; if_fault tied 0; FAULT state absent.

Test Plan:
- Reset, then rst=0, imem always ready, 1-cycle memory, if_ready=1 → requests at 0x01000000, 0x01000004, 0x01000008…; first if_valid with if_pc=0x01000000 two cycles after first accept; one instruction per cycle steady state.
- if_ready=0 for 5 cycles → exactly BUF_DEPTH (2) responses buffered; imem_req_valid=0 afterwards; no loss or reorder on release.
- 2 requests outstanding, redirect_valid=1 with redirect_pc=0x01000100 → both stale responses dropped; next if_pc=0x01000100; pc_next=0x01000100 in redirect cycle.
- Redirect coincident with a response and with imem_req_ready=1 → no request issued that cycle, response dropped, discard count correct.
- halt=1 for 4 cycles mid-stream → no new requests, in-flight words delivered; resumes at the correct PC when halt=0.
- With FETCH_MISALIGN_TRAP_EN, redirect_pc=0x01000102 → single entry if_fault=1, if_pc=0x01000102; no imem requests until a redirect to 0x01000200 resumes fetch.
